// File: rtl/fp_norm_round_stage_if.sv
// Handshake and data bundle for the normalise-and-round stage.
// slave: the stage itself; master: whatever drives it and consumes its result.
interface fp_norm_round_stage_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W+1:0]       in_exp;
  logic [MAN_W+2:0]       in_mant;
  logic                   in_sticky;
  logic                   in_zero;
  logic                   in_nan;
  logic [1:0]             rnd_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_data;
  logic [3:0]             out_flags;
  logic [3:0]             acc_flags;
  logic                   flag_clr;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_zero, in_nan, rnd_mode,
    input  out_ready, flag_clr,
    output in_ready, out_valid, out_data, out_flags, acc_flags
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_zero, in_nan, rnd_mode,
    output out_ready, flag_clr,
    input  in_ready, out_valid, out_data, out_flags, acc_flags
  );
endinterface

// File: rtl/fp_norm_round_stage.sv
// Normalise (by at most one bit), round in one of four IEEE modes, detect
// exceptions and pack the IEEE result. One registered stage with valid/ready
// handshake and sticky accumulated exception flags {NV, OF, UF, NX}.
module fp_norm_round_stage #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_norm_round_stage_if.slave  bus
);
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned MW = MAN_W + 3;
  localparam int unsigned DW = EXP_W + MAN_W + 1;

  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_OVF  = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rnd_e;

  logic                 accept;
  logic                 norm;
  logic [MAN_W:0]       kept;
  logic                 g, s, nx, inc, carry, to_inf, sign;
  rnd_e                 mode;
  logic signed [EW-1:0] e_norm, e_rnd;
  logic [MAN_W+1:0]     sum;
  logic [MAN_W-1:0]     frac;
  logic [DW-1:0]        res_data;
  logic [3:0]           res_flags;
  logic                 unused_hidden;

  logic                 out_valid_d, out_valid_q;
  logic [DW-1:0]        out_data_d,  out_data_q;
  logic [3:0]           out_flags_d, out_flags_q;
  logic [3:0]           acc_flags_d, acc_flags_q;

  // Handshake: accept whenever the output register is empty or being drained.
  always_comb begin
    bus.in_ready  = !out_valid_q || bus.out_ready;
    accept        = bus.in_valid && bus.in_ready;
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_flags = out_flags_q;
    bus.acc_flags = acc_flags_q;
  end

  // Normalise, round, classify and pack the incoming product.
  always_comb begin
    sign = bus.in_sign;
    mode = rnd_e'(bus.rnd_mode);
    norm = bus.in_mant[MW-1];
    if (norm) begin
      kept = bus.in_mant[MW-1:2];
      g    = bus.in_mant[1];
      s    = bus.in_mant[0] | bus.in_sticky;
    end else begin
      kept = bus.in_mant[MW-2:1];
      g    = bus.in_mant[0];
      s    = bus.in_sticky;
    end
    e_norm = $signed(bus.in_exp) + (norm ? E_ONE : E_ZERO);
    nx     = g | s;

    inc = 1'b0;
    case (mode)
      RNE:     inc = g & (s | kept[0]);
      RTZ:     inc = 1'b0;
      RUP:     inc = nx & ~sign;
      RDN:     inc = nx & sign;
      default: inc = 1'b0;
    endcase

    // A carry out of the hidden bit leaves exactly 1.0, so the fraction is zero.
    sum           = {1'b0, kept} + (MAN_W+2)'(inc);
    carry         = sum[MAN_W+1];
    unused_hidden = sum[MAN_W];
    frac          = carry ? '0 : sum[MAN_W-1:0];
    e_rnd         = e_norm + (carry ? E_ONE : E_ZERO);

    to_inf = (mode == RNE) || ((mode == RUP) && !sign) || ((mode == RDN) && sign);

    res_data  = {sign, e_rnd[EXP_W-1:0], frac};
    res_flags = {3'b000, nx};
    if (bus.in_nan) begin
      res_data  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      res_flags = 4'b1000;
    end else if (bus.in_zero) begin
      res_data  = {sign, {(DW-1){1'b0}}};
      res_flags = 4'b0000;
    end else if (e_rnd >= E_OVF) begin
      if (to_inf)
        res_data = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
        res_data = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      res_flags = 4'b0101;
    end else if (e_rnd <= E_ZERO) begin
      res_data  = {sign, {(DW-1){1'b0}}};
      res_flags = 4'b0011;
    end
  end

  // Next-state for the output register and sticky flags.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = res_data;
      out_flags_d = res_flags;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // New flags are ORed after the clear so they survive a simultaneous clear.
    acc_flags_d = (bus.flag_clr ? 4'b0000 : acc_flags_q) | (accept ? res_flags : 4'b0000);
  end

  // Output and flag registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      acc_flags_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      acc_flags_q <= acc_flags_d;
    end
  end
endmodule

// File: tb/tb_fp_norm_round_stage.sv
// Bench for fp_norm_round_stage (EXP_W=8, MAN_W=23): directed literal vectors,
// a stall/reset sequence and randomized traffic against an arithmetic model.
module tb_fp_norm_round_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fp_norm_round_stage_if #(.EXP_W(8), .MAN_W(23)) bus();

  fp_norm_round_stage #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: treat the product as an integer, divide by 2 or 4, round the
  // quotient using remainder-versus-half, then apply IEEE range rules.
  function automatic logic [35:0] model(input logic sg, input int e_in, input logic [25:0] mant,
                                        input logic st, input logic z, input logic n,
                                        input logic [1:0] md);
    longint m, q, r, half;
    int     sh, e;
    logic   nx, up, to_inf;
    if (n) return {4'b1000, 32'h7FC00000};
    if (z) return {4'b0000, sg, 31'h0};
    m    = longint'(mant);
    sh   = mant[25] ? 2 : 1;
    e    = e_in + sh - 1;
    q    = m >> sh;
    r    = ((m % (longint'(1) << sh)) << 1) + longint'(st);
    half = longint'(1) << sh;
    nx   = (r != 0);
    case (md)
      2'd0:    up = (r > half) || ((r == half) && (q % 2 == 1));
      2'd1:    up = 1'b0;
      2'd2:    up = nx && !sg;
      default: up = nx && sg;
    endcase
    if (up) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      to_inf = (md == 2'd0) || (md == 2'd2 && !sg) || (md == 2'd3 && sg);
      return {4'b0101, to_inf ? {sg, 31'h7F800000} : {sg, 31'h7F7FFFFF}};
    end
    if (e <= 0) return {4'b0011, sg, 31'h0};
    return {3'b000, nx, sg, 8'(e), 23'(q)};
  endfunction

  // Scoreboard state: pending results and expected sticky flags.
  logic [35:0] exp_q[$];
  logic [3:0]  acc_m = 4'h0;

  // Track what the stage must have accepted/drained at each edge.
  always @(posedge clk or negedge reset) begin
    logic [35:0] r;
    logic        acc, drain;
    if (!reset) begin
      exp_q.delete();
      acc_m = 4'h0;
    end else begin
      drain = (exp_q.size() > 0) && bus.out_ready;
      acc   = bus.in_valid && ((exp_q.size() == 0) || bus.out_ready);
      r     = model(bus.in_sign, int'($signed(bus.in_exp)), bus.in_mant, bus.in_sticky,
                    bus.in_zero, bus.in_nan, bus.rnd_mode);
      acc_m = (bus.flag_clr ? 4'h0 : acc_m) | (acc ? r[35:32] : 4'h0);
      if (drain) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(r);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_valid", 64'(bus.out_valid), 64'(0));
      check("rst_data",  64'(bus.out_data),  64'(0));
      check("rst_flags", 64'(bus.out_flags), 64'(0));
      check("rst_acc",   64'(bus.acc_flags), 64'(0));
    end else begin
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      check("in_ready",  64'(bus.in_ready),  64'((exp_q.size() == 0) || bus.out_ready));
      if (exp_q.size() > 0) begin
        check("out_data",  64'(bus.out_data),  64'(exp_q[0][31:0]));
        check("out_flags", 64'(bus.out_flags), 64'(exp_q[0][35:32]));
      end
      check("acc_flags", 64'(bus.acc_flags), 64'(acc_m));
    end
  end

  task automatic drive(input logic sg, input int e, input logic [25:0] m, input logic st,
                       input logic z, input logic n, input logic [1:0] md);
    bus.in_sign   = sg;
    bus.in_exp    = 10'(e);
    bus.in_mant   = m;
    bus.in_sticky = st;
    bus.in_zero   = z;
    bus.in_nan    = n;
    bus.rnd_mode  = md;
  endtask

  // One transaction with the output drained, checked against literals.
  task automatic dir(input string nm, input logic sg, input int e, input logic [25:0] m,
                     input logic st, input logic z, input logic n, input logic [1:0] md,
                     input logic clr, input logic [31:0] xd, input logic [3:0] xf);
    logic [35:0] mr;
    @(posedge clk); #1;
    drive(sg, e, m, st, z, n, md);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.flag_clr  = clr;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flag_clr = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, 64'(bus.out_valid), 64'(1));
    check({nm, "_data"},  64'(bus.out_data),  64'(xd));
    check({nm, "_flags"}, 64'(bus.out_flags), 64'(xf));
    mr = model(sg, e, m, st, z, n, md);
    check({nm, "_model"}, 64'(mr), 64'({xf, xd}));
  endtask

  initial begin
    logic [31:0] held;
    logic [25:0] m;
    int          e;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flag_clr  = 1'b0;
    drive(1'b0, 0, 26'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    dir("one",      1'b0, 127, 26'h1000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h3F800000, 4'b0000);
    dir("two",      1'b0, 127, 26'h2000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h40000000, 4'b0000);
    dir("carry",    1'b0, 127, 26'h1FFFFFF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h40000000, 4'b0001);
    dir("rtz",      1'b0, 127, 26'h1FFFFFF, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h3FFFFFFF, 4'b0001);
    dir("of_rne",   1'b0, 254, 26'h2000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h7F800000, 4'b0101);
    dir("of_rtz",   1'b0, 254, 26'h2000000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h7F7FFFFF, 4'b0101);
    dir("of_rup_n", 1'b1, 254, 26'h2000000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'hFF7FFFFF, 4'b0101);
    dir("uf",       1'b1, 0,   26'h1000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h80000000, 4'b0011);
    dir("nan",      1'b1, 5,   26'h1000000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h7FC00000, 4'b1000);
    dir("zero",     1'b1, 5,   26'h0000000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h80000000, 4'b0000);
    // acc_flags is non-zero here; the clear coincides with an OF accept.
    dir("clr_of",   1'b0, 254, 26'h2000000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h7F800000, 4'b0101);
    check("clr_of_acc", 64'(bus.acc_flags), 64'(4'b0101));

    // Stall: first item accepted, second waits while out_ready is low.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(1'b0, 100, 26'h1234567, 1'b1, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    drive(1'b1, 130, 26'h2ABCDEF, 1'b0, 1'b0, 1'b0, 2'd3);
    @(negedge clk);
    held = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready",  64'(bus.in_ready), 64'(0));
      check("stall_stable", 64'(bus.out_data), 64'(held));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Randomized traffic with random back-pressure and clears.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      m = 26'($urandom);
      if ($urandom_range(0, 1) == 0) m[25] = 1'b1;
      else m[25:24] = 2'b01;
      if ($urandom_range(0, 7) == 0) m[23:0] = '1;
      case ($urandom_range(0, 3))
        0:       e = int'($urandom_range(0, 6)) - 3;
        1:       e = 250 + int'($urandom_range(0, 8));
        2:       e = int'($urandom_range(1, 254));
        default: e = int'($urandom_range(0, 900)) - 450;
      endcase
      drive(1'($urandom), e, m, 1'($urandom), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0), 2'($urandom));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flag_clr  = ($urandom_range(0, 15) == 0);
    end

    // Reset in the middle of a stall discards everything.
    @(posedge clk); #1;
    bus.flag_clr  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(1'b0, 254, 26'h2000000, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_data",  64'(bus.out_data),  64'(0));
    check("midrst_flags", 64'(bus.out_flags), 64'(0));
    check("midrst_acc",   64'(bus.acc_flags), 64'(0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
